// File: rtl/image_loader_pkg.sv
// Shared definitions for the image frame loader.
// State encoding, header length and frame start byte.
package image_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_CHECK,
    S_PIX,
    S_WAIT_ACK
  } state_t;

  localparam int HDR_LEN = 4;
  localparam logic [7:0] MAGIC_DEF = 8'hA5;

  function automatic logic [31:0] calc_total(
    input logic [15:0] w,
    input logic [15:0] h
  );
    return {16'h0, w} * {16'h0, h};
  endfunction

endpackage

// File: rtl/image_loader_rise_detect.sv
// Rising-edge detector with configurable history reset value.
// rise is same-cycle, pulse is the registered copy.
module rise_detect #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic pulse
);

  logic prev;

  assign rise = d & ~prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev  <= RST_VAL;
      pulse <= 1'b0;
    end else begin
      prev  <= d;
      pulse <= rise;
    end
  end

endmodule

// File: rtl/image_loader.sv
// Serial byte stream to SRAM image loader.
// Parses magic/width/height header, packs pixel pairs into words.
module image_loader
  import image_loader_pkg::*;
#(
  parameter logic [7:0] MAGIC = MAGIC_DEF,
  parameter int ADDR_W         = 18,
  parameter int BASE_ADDR      = 0,
  parameter int MAX_PIXELS     = 524288,
  parameter int TIMEOUT_CYCLES = 2400000
) (
  input  logic              CLOCK_24,
  input  logic              reset_n,
  input  logic              rx_ready,
  input  logic [7:0]        rx_data,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic [1:0]        wr_be,
  input  logic              wr_ack,
  output logic              busy,
  output logic              done,
  output logic [15:0]       frame_w,
  output logic [15:0]       frame_h,
  output logic              err_magic,
  output logic              err_size,
  output logic              err_timeout,
  output logic              err_overflow
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] MAX_TOT = 32'(MAX_PIXELS);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam longint LAST_ADDR =
    longint'(BASE_ADDR) + (longint'(MAX_PIXELS) + 1) / 2 - 1;

  if (LAST_ADDR >= (longint'(1) << ADDR_W)) begin : g_addr_chk
    $error("image_loader: pixel buffer exceeds ADDR_W");
  end

  state_t            state;
  logic              rise;
  logic              stb;
  logic [7:0]        byte_q;
  logic [1:0]        hdr_cnt;
  logic [15:0]       w_q;
  logic [15:0]       h_q;
  logic [31:0]       total;
  logic [31:0]       tot_c;
  logic [31:0]       pix_cnt;
  logic [7:0]        low_q;
  logic [TW-1:0]     tcnt;
  logic              ovf_q;
  logic              last_pix;
  logic              t_run;
  logic              t_hit;

  rise_detect #(
    .RST_VAL(1'b1)
  ) u_rx (
    .clk  (CLOCK_24),
    .rst_n(reset_n),
    .d    (rx_ready),
    .rise (rise),
    .pulse(stb)
  );

  assign busy     = (state != S_IDLE);
  assign tot_c    = calc_total(w_q, h_q);
  assign last_pix = (pix_cnt + 32'd1 == total);
  assign t_run    = (state == S_HDR) || (state == S_CHECK)
                 || (state == S_PIX);
  assign t_hit    = t_run && !stb && !wr_req && (tcnt == T_LAST);

  always_ff @(posedge CLOCK_24) begin
    if (!reset_n) begin
      byte_q <= 8'h00;
    end else if (rise) begin
      byte_q <= rx_data;
    end
  end

  always_ff @(posedge CLOCK_24) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      hdr_cnt      <= 2'd0;
      w_q          <= 16'h0;
      h_q          <= 16'h0;
      total        <= 32'h0;
      pix_cnt      <= 32'h0;
      low_q        <= 8'h00;
      tcnt         <= '0;
      ovf_q        <= 1'b0;
      wr_req       <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= 16'h0;
      wr_be        <= 2'b00;
      done         <= 1'b0;
      frame_w      <= 16'h0;
      frame_h      <= 16'h0;
      err_magic    <= 1'b0;
      err_size     <= 1'b0;
      err_timeout  <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      done <= 1'b0;

      if (wr_req && wr_ack) begin
        wr_req  <= 1'b0;
        wr_addr <= wr_addr + ADDR_W'(1);
      end

      // idle gap timer, frozen while a write is outstanding
      if (stb) begin
        tcnt <= '0;
      end else if (t_run && !wr_req) begin
        tcnt <= tcnt + TW'(1);
      end

      unique case (state)
        S_IDLE: begin
          if (stb) begin
            if (byte_q == MAGIC) begin
              err_magic    <= 1'b0;
              err_size     <= 1'b0;
              err_timeout  <= 1'b0;
              err_overflow <= 1'b0;
              ovf_q        <= 1'b0;
              hdr_cnt      <= 2'd0;
              state        <= S_HDR;
            end else begin
              err_magic <= 1'b1;
            end
          end
        end

        S_HDR: begin
          if (stb) begin
            hdr_cnt <= hdr_cnt + 2'd1;
            unique case (hdr_cnt)
              2'd0: w_q[15:8] <= byte_q;
              2'd1: w_q[7:0]  <= byte_q;
              2'd2: h_q[15:8] <= byte_q;
              2'd3: begin
                h_q[7:0] <= byte_q;
                state    <= S_CHECK;
              end
              default: ;
            endcase
          end else if (t_hit) begin
            err_timeout <= 1'b1;
            state       <= S_IDLE;
          end
        end

        S_CHECK: begin
          if (tot_c == 32'h0 || tot_c > MAX_TOT) begin
            err_size <= 1'b1;
            state    <= S_IDLE;
          end else begin
            total   <= tot_c;
            pix_cnt <= 32'h0;
            wr_addr <= BASE;
            state   <= S_PIX;
          end
        end

        S_PIX: begin
          if (stb) begin
            pix_cnt <= pix_cnt + 32'd1;
            if (!pix_cnt[0]) begin
              low_q <= byte_q;
            end
            if (!pix_cnt[0] && !last_pix) begin
              // even pixel mid-frame: just buffered
            end else if (wr_req) begin
              err_overflow <= 1'b1;
              ovf_q        <= 1'b1;
              state        <= S_WAIT_ACK;
            end else begin
              wr_req <= 1'b1;
              if (pix_cnt[0]) begin
                wr_data <= {byte_q, low_q};
                wr_be   <= 2'b11;
              end else begin
                wr_data <= {8'h00, byte_q};
                wr_be   <= 2'b01;
              end
              if (last_pix) begin
                state <= S_WAIT_ACK;
              end
            end
          end else if (t_hit) begin
            err_timeout <= 1'b1;
            state       <= S_IDLE;
          end
        end

        S_WAIT_ACK: begin
          if (!wr_req) begin
            ovf_q <= 1'b0;
            state <= S_IDLE;
          end else if (wr_ack) begin
            if (!ovf_q) begin
              done    <= 1'b1;
              frame_w <= w_q;
              frame_h <= h_q;
            end
            ovf_q <= 1'b0;
            state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_image_loader.sv
// Directed self-checking bench for image_loader.
// Arbiter model acks two cycles after each request.
module tb_image_loader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rx_ready = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        wr_req;
  logic [17:0] wr_addr;
  logic [15:0] wr_data;
  logic [1:0]  wr_be;
  logic        wr_ack = 1'b0;
  logic        busy;
  logic        done;
  logic [15:0] frame_w;
  logic [15:0] frame_h;
  logic        err_magic;
  logic        err_size;
  logic        err_timeout;
  logic        err_overflow;

  int checks = 0;
  int errors = 0;
  int nwr = 0;
  int ndone = 0;
  int req_age = 0;
  logic ack_en = 1'b1;
  logic [17:0] la [32];
  logic [15:0] ld [32];
  logic [1:0]  lb [32];

  always #5 clk = ~clk;

  image_loader #(
    .TIMEOUT_CYCLES(100)
  ) dut (
    .CLOCK_24    (clk),
    .reset_n     (reset_n),
    .rx_ready    (rx_ready),
    .rx_data     (rx_data),
    .wr_req      (wr_req),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_be       (wr_be),
    .wr_ack      (wr_ack),
    .busy        (busy),
    .done        (done),
    .frame_w     (frame_w),
    .frame_h     (frame_h),
    .err_magic   (err_magic),
    .err_size    (err_size),
    .err_timeout (err_timeout),
    .err_overflow(err_overflow)
  );

  always @(negedge clk) begin
    if (!reset_n) begin
      wr_ack  = 1'b0;
      req_age = 0;
    end else if (wr_ack) begin
      wr_ack = 1'b0;
    end else if (wr_req && ack_en) begin
      req_age++;
      if (req_age == 2) begin
        wr_ack  = 1'b1;
        req_age = 0;
        if (nwr < 32) begin
          la[nwr] = wr_addr;
          ld[nwr] = wr_data;
          lb[nwr] = wr_be;
        end
        nwr++;
      end
    end else begin
      req_age = 0;
    end
  end

  always @(negedge clk) begin
    if (done) ndone++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input int hold = 3);
    @(negedge clk);
    rx_data  = b;
    rx_ready = 1'b1;
    repeat (hold) @(negedge clk);
    rx_ready = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
  endtask

  logic [7:0] f22 [9] = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h02,
                          8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] f13 [8] = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h03,
                          8'h11, 8'h22, 8'h33};
  logic [7:0] fz  [5] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h05};

  initial begin
    int n0;
    int d0;

    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst busy", 32'(busy), 0);
    chk("rst wr_req", 32'(wr_req), 0);
    chk("rst done", 32'(done), 0);
    chk("rst wr_addr", 32'(wr_addr), 0);
    chk("rst frame_w", 32'(frame_w), 0);
    chk("rst errs", 32'({err_magic, err_size, err_timeout, err_overflow}), 0);

    n0 = nwr;
    d0 = ndone;
    foreach (f22[i]) send(f22[i]);
    wait_idle();
    chk("2x2 nwr", 32'(nwr - n0), 2);
    chk("2x2 w0 addr", 32'(la[n0]), 0);
    chk("2x2 w0 data", {14'h0, lb[n0], ld[n0]}, 32'h3_2211);
    chk("2x2 w1 addr", 32'(la[n0+1]), 1);
    chk("2x2 w1 data", {14'h0, lb[n0+1], ld[n0+1]}, 32'h3_4433);
    chk("2x2 done", 32'(ndone - d0), 1);
    chk("2x2 frame_w", 32'(frame_w), 2);
    chk("2x2 frame_h", 32'(frame_h), 2);
    chk("2x2 errs", 32'({err_magic, err_size, err_timeout, err_overflow}), 0);

    n0 = nwr;
    d0 = ndone;
    foreach (f13[i]) send(f13[i]);
    wait_idle();
    chk("1x3 nwr", 32'(nwr - n0), 2);
    chk("1x3 w0 addr", 32'(la[n0]), 0);
    chk("1x3 w0 data", {14'h0, lb[n0], ld[n0]}, 32'h3_2211);
    chk("1x3 w1 addr", 32'(la[n0+1]), 1);
    chk("1x3 w1 data", {14'h0, lb[n0+1], ld[n0+1]}, 32'h1_0033);
    chk("1x3 done", 32'(ndone - d0), 1);
    chk("1x3 frame_w", 32'(frame_w), 1);
    chk("1x3 frame_h", 32'(frame_h), 3);

    n0 = nwr;
    send(8'h5A);
    chk("magic err set", 32'(err_magic), 1);
    chk("magic idle", 32'(busy), 0);
    send(fz[0]);
    chk("magic cleared", 32'(err_magic), 0);
    chk("magic busy", 32'(busy), 1);
    for (int i = 1; i < 5; i++) send(fz[i]);
    chk("size err", 32'(err_size), 1);
    chk("size idle", 32'(busy), 0);
    chk("size nwr", 32'(nwr - n0), 0);

    send(8'hA5);
    send(8'h00);
    send(8'h02);
    repeat (80) @(negedge clk);
    chk("tmo early", 32'(err_timeout), 0);
    chk("tmo early busy", 32'(busy), 1);
    repeat (20) @(negedge clk);
    chk("tmo err", 32'(err_timeout), 1);
    chk("tmo idle", 32'(busy), 0);
    chk("tmo frame_w", 32'(frame_w), 1);

    n0 = nwr;
    d0 = ndone;
    ack_en = 1'b0;
    foreach (f22[i]) send(f22[i]);
    chk("ovf err", 32'(err_overflow), 1);
    chk("ovf pending", 32'(wr_req), 1);
    chk("ovf no write", 32'(nwr - n0), 0);
    ack_en = 1'b1;
    wait_idle();
    chk("ovf nwr", 32'(nwr - n0), 1);
    chk("ovf w0 data", {14'h0, lb[n0], ld[n0]}, 32'h3_2211);
    chk("ovf no done", 32'(ndone - d0), 0);
    chk("ovf idle", 32'(busy), 0);
    chk("ovf req low", 32'(wr_req), 0);

    reset_n  = 1'b0;
    rx_data  = 8'h5A;
    rx_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("held no byte", 32'(err_magic), 0);
    chk("held idle", 32'(busy), 0);
    rx_ready = 1'b0;
    repeat (5) @(negedge clk);
    n0 = nwr;
    d0 = ndone;
    send(8'hA5, 50);
    chk("held hdr", 32'(busy), 1);
    for (int i = 1; i < 9; i++) send(f22[i]);
    wait_idle();
    chk("held nwr", 32'(nwr - n0), 2);
    chk("held w1 data", {14'h0, lb[n0+1], ld[n0+1]}, 32'h3_4433);
    chk("held done", 32'(ndone - d0), 1);
    chk("held frame_w", 32'(frame_w), 2);
    chk("held frame_h", 32'(frame_h), 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
